// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle between the SPI master control FSM (master side)
// and the frame-based SCLK generator (slave side).
interface spi_sclk_gen_if #(
  parameter int unsigned SPPR_W  = 3,
  parameter int unsigned SPR_W   = 3,
  parameter int unsigned BRD_W   = 12,
  parameter int unsigned FRAME_W = 5
);
  logic [1:0]         spi_mode_i;
  logic               spiswai_i;
  logic [SPPR_W-1:0]  sppr_i;
  logic [SPR_W-1:0]   spr_i;
  logic               cpol_i;
  logic               cpha_i;
  logic [FRAME_W-1:0] frame_len_i;
  logic               start_i;
  logic               abort_i;
  logic               sclk_o;
  logic               sample_stb_o;
  logic               shift_stb_o;
  logic               busy_o;
  logic               done_o;
  logic [FRAME_W-1:0] bit_cnt_o;
  logic [BRD_W-1:0]   brd_o;

  modport master (
    output spi_mode_i, spiswai_i, sppr_i, spr_i, cpol_i, cpha_i, frame_len_i, start_i, abort_i,
    input  sclk_o, sample_stb_o, shift_stb_o, busy_o, done_o, bit_cnt_o, brd_o
  );

  modport slave (
    input  spi_mode_i, spiswai_i, sppr_i, spr_i, cpol_i, cpha_i, frame_len_i, start_i, abort_i,
    output sclk_o, sample_stb_o, shift_stb_o, busy_o, done_o, bit_cnt_o, brd_o
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Frame-based SPI serial-clock generator: emits frame_len SCLK cycles per start request,
// with per-edge sample/shift strobes, pause in wait/stop mode and abort.
module spi_sclk_gen #(
  parameter int unsigned SPPR_W  = 3,
  parameter int unsigned SPR_W   = 3,
  parameter int unsigned BRD_W   = 12,
  parameter int unsigned FRAME_W = 5
) (
  input logic           pclk,
  input logic           preset,
  spi_sclk_gen_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StTail  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [1:0]         saved_q, saved_d;
  logic [1:0]         eff_state;
  logic [BRD_W-1:0]   hcnt_q, hcnt_d;
  logic [BRD_W-1:0]   half_q, half_d;
  logic [FRAME_W:0]   ecnt_q, ecnt_d;
  logic [FRAME_W:0]   edge_num, last_edge;
  logic [FRAME_W-1:0] len_q, len_d;
  logic [FRAME_W-1:0] bit_cnt_q, bit_cnt_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               sclk_q, sclk_d;
  logic               sample_q, sample_d;
  logic               shift_q, shift_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pause_cond;
  logic               half_wrap;
  logic [BRD_W-1:0]   presel;
  logic [SPR_W:0]     shamt;
  logic [BRD_W-1:0]   brd;

  // Divisor = (sppr+1) * 2^(spr+1); shift amount widened so spr=max does not wrap.
  assign presel = BRD_W'(bus.sppr_i) + BRD_W'(1);
  assign shamt  = {1'b0, bus.spr_i} + (SPR_W + 1)'(1);
  assign brd    = presel << shamt;

  assign pause_cond = bus.spi_mode_i[1] || ((bus.spi_mode_i == 2'b01) && bus.spiswai_i);
  assign eff_state  = (state_q == StPause) ? saved_q : state_q;
  assign edge_num   = ecnt_q + (FRAME_W + 1)'(1);
  assign last_edge  = {len_q, 1'b0};
  assign half_wrap  = (hcnt_q == half_q - BRD_W'(1));

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    hcnt_d    = hcnt_q;
    half_d    = half_q;
    ecnt_d    = ecnt_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q == StIdle) begin
      sclk_d = bus.cpol_i;
      if (bus.start_i && (bus.frame_len_i != '0) && !bus.abort_i && !pause_cond) begin
        cpol_d    = bus.cpol_i;
        cpha_d    = bus.cpha_i;
        half_d    = brd >> 1;
        len_d     = bus.frame_len_i;
        hcnt_d    = '0;
        ecnt_d    = '0;
        bit_cnt_d = '0;
        busy_d    = 1'b1;
        state_d   = StRun;
      end
    end else if (bus.abort_i) begin
      sclk_d  = cpol_q;
      busy_d  = 1'b0;
      state_d = StIdle;
    end else if (pause_cond) begin
      // Freeze everything; remember where to resume.
      if (state_q != StPause) begin
        saved_d = state_q;
      end
      state_d = StPause;
    end else begin
      state_d = eff_state;
      if (!half_wrap) begin
        hcnt_d = hcnt_q + BRD_W'(1);
      end else begin
        hcnt_d = '0;
        if (eff_state == StRun) begin
          sclk_d = ~sclk_q;
          ecnt_d = edge_num;
          if (edge_num[0]) begin
            if (cpha_q) shift_d = 1'b1;
            else        sample_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + FRAME_W'(1);
            if (cpha_q)                      sample_d = 1'b1;
            else if (edge_num != last_edge)  shift_d  = 1'b1;
          end
          if (edge_num == last_edge) begin
            state_d = StTail;
          end
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= StIdle;
      saved_q   <= StIdle;
      hcnt_q    <= '0;
      half_q    <= '0;
      ecnt_q    <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= bus.cpol_i;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      hcnt_q    <= hcnt_d;
      half_q    <= half_d;
      ecnt_q    <= ecnt_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk_o       = sclk_q;
  assign bus.sample_stb_o = sample_q;
  assign bus.shift_stb_o  = shift_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.bit_cnt_o    = bit_cnt_q;
  assign bus.brd_o        = brd;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: per-cycle comparison against a timing model
// derived from the frame rules (elapsed active cycles -> edges -> outputs).
module tb_spi_sclk_gen;
  localparam int unsigned SPPR_W  = 3;
  localparam int unsigned SPR_W   = 3;
  localparam int unsigned BRD_W   = 12;
  localparam int unsigned FRAME_W = 5;
  localparam int          OW      = FRAME_W + 5;

  logic pclk = 1'b0;
  logic preset;
  int   checks = 0;
  int   passed = 0;

  always #5 pclk = ~pclk;

  spi_sclk_gen_if #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .BRD_W(BRD_W), .FRAME_W(FRAME_W)) bus ();

  spi_sclk_gen #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .BRD_W(BRD_W), .FRAME_W(FRAME_W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  function automatic logic [OW-1:0] observed();
    return {bus.sclk_o, bus.sample_stb_o, bus.shift_stb_o, bus.busy_o, bus.done_o, bus.bit_cnt_o};
  endfunction

  // Expected {sclk, sample, shift, busy, done, bit_cnt} after `act` unpaused cycles since acceptance.
  function automatic logic [OW-1:0] model(input int act, input bit paused, input int half,
                                          input int n, input bit cpol, input bit cpha);
    int e, k, fin;
    bit smp, shf, busy, done;
    fin = (2 * n + 1) * half;
    e   = (act >= 2 * n * half) ? 2 * n : act / half;
    smp = 1'b0;
    shf = 1'b0;
    k   = act / half;
    if (!paused && (act % half == 0) && k >= 1 && k <= 2 * n) begin
      if (k % 2 == 1) begin
        if (cpha) shf = 1'b1; else smp = 1'b1;
      end else begin
        if (cpha) smp = 1'b1; else if (k != 2 * n) shf = 1'b1;
      end
    end
    busy = (act < fin);
    done = !paused && (act == fin);
    return {cpol ^ e[0], smp, shf, busy, done, FRAME_W'(e / 2)};
  endfunction

  // Runs one frame, checking every cycle; pause/abort/mid-frame-start are optional.
  task automatic test_frame(input string name, input int sppr, input int spr, input bit cpol,
                            input bit cpha, input int n, input int pause_at, input int pause_len,
                            input bit rnd_pause, input int abort_at, input int mid_start_at,
                            output int done_cyc, output int smp_cnt, output int shf_cnt);
    int half, fin, act, c, left, exp_brd;
    bit paused, pause_used;
    logic [OW-1:0] exp_v, got_v;
    exp_brd  = (sppr + 1) * (1 << (spr + 1));
    half     = exp_brd / 2;
    fin      = (2 * n + 1) * half;
    done_cyc = -1;
    smp_cnt  = 0;
    shf_cnt  = 0;
    bus.sppr_i      = SPPR_W'(sppr);
    bus.spr_i       = SPR_W'(spr);
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.frame_len_i = FRAME_W'(n);
    bus.spi_mode_i  = 2'b00;
    bus.spiswai_i   = 1'b0;
    #1;
    checks++;
    if (bus.brd_o !== BRD_W'(exp_brd))
      $display("FAIL %s brd: got %0d expected %0d", name, bus.brd_o, exp_brd);
    else passed++;
    bus.start_i = 1'b1;
    @(posedge pclk); #1;
    bus.start_i = 1'b0;
    act = 0; c = 0; left = 0; pause_used = 1'b0;
    got_v = observed();
    exp_v = model(0, 1'b0, half, n, cpol, cpha);
    checks++;
    if (got_v !== exp_v) $display("FAIL %s accept: got %b expected %b", name, got_v, exp_v);
    else passed++;
    while (act < fin && c < 2 * fin + 200) begin
      paused = 1'b0;
      bus.spi_mode_i = 2'b00;
      bus.spiswai_i  = 1'b0;
      if (!pause_used && pause_len > 0 && act == pause_at) begin
        left = pause_len;
        pause_used = 1'b1;
      end
      if (left > 0) begin
        bus.spi_mode_i = 2'b01;
        bus.spiswai_i  = 1'b1;
        paused = 1'b1;
        left--;
      end else if (rnd_pause && $urandom_range(0, 7) == 0) begin
        bus.spi_mode_i = 2'($urandom_range(0, 3));
        bus.spiswai_i  = 1'($urandom_range(0, 1));
        paused = bus.spi_mode_i[1] || (bus.spi_mode_i == 2'b01 && bus.spiswai_i);
      end
      bus.abort_i = (c + 1 == abort_at);
      if (c + 1 == mid_start_at) begin
        bus.start_i     = 1'b1;
        bus.frame_len_i = FRAME_W'($urandom_range(1, 31));
        bus.cpha_i      = ~cpha;
        bus.sppr_i      = SPPR_W'($urandom_range(0, 7));
        bus.spr_i       = SPR_W'($urandom_range(0, 7));
      end
      @(posedge pclk); #1;
      c++;
      bus.start_i = 1'b0;
      if (bus.abort_i) begin
        bus.abort_i = 1'b0;
        checks++;
        if (observed() >> FRAME_W !== {cpol, 4'b0000})
          $display("FAIL %s abort cyc %0d: got %b expected %b", name, c, observed() >> FRAME_W,
                   {cpol, 4'b0000});
        else passed++;
        bus.spi_mode_i = 2'b00;
        bus.spiswai_i  = 1'b0;
        return;
      end
      if (!paused) act++;
      got_v = observed();
      exp_v = model(act, paused, half, n, cpol, cpha);
      checks++;
      if (got_v !== exp_v)
        $display("FAIL %s cyc %0d act %0d: got %b expected %b", name, c, act, got_v, exp_v);
      else passed++;
      if (bus.sample_stb_o) smp_cnt++;
      if (bus.shift_stb_o)  shf_cnt++;
      if (bus.done_o) done_cyc = c;
    end
    bus.spi_mode_i = 2'b00;
    bus.spiswai_i  = 1'b0;
    checks++;
    if (act < fin) $display("FAIL %s timeout: got act %0d expected %0d", name, act, fin);
    else passed++;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp_v;
    preset = 1'b1;
    bus.cpol_i = 1'b1;
    @(posedge pclk); #1;
    exp_v = {1'b1, 4'b0000, FRAME_W'(0)};
    checks++;
    if (observed() !== exp_v) $display("FAIL reset_cpol1: got %b expected %b", observed(), exp_v);
    else passed++;
    bus.cpol_i = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (observed() !== OW'(0)) $display("FAIL reset_idle: got %b expected %b", observed(), OW'(0));
    else passed++;
  endtask

  task automatic test_mode0();
    int dc, sm, sh;
    test_frame("mode0", 2, 1, 1'b0, 1'b0, 8, -1, 0, 1'b0, -1, -1, dc, sm, sh);
    checks++; if (dc !== 102) $display("FAIL mode0_done: got %0d expected 102", dc); else passed++;
    checks++; if (sm !== 8) $display("FAIL mode0_samples: got %0d expected 8", sm); else passed++;
    checks++; if (sh !== 7) $display("FAIL mode0_shifts: got %0d expected 7", sh); else passed++;
  endtask

  task automatic test_mode3_fast();
    int dc, sm, sh;
    test_frame("mode3", 0, 0, 1'b1, 1'b1, 4, -1, 0, 1'b0, -1, -1, dc, sm, sh);
    checks++; if (dc !== 9) $display("FAIL mode3_done: got %0d expected 9", dc); else passed++;
    checks++; if (sm !== 4) $display("FAIL mode3_samples: got %0d expected 4", sm); else passed++;
    checks++; if (sh !== 4) $display("FAIL mode3_shifts: got %0d expected 4", sh); else passed++;
  endtask

  task automatic test_pause();
    int dc, sm, sh;
    test_frame("pause", 2, 1, 1'b0, 1'b0, 8, 18, 20, 1'b0, -1, -1, dc, sm, sh);
    checks++; if (dc !== 122) $display("FAIL pause_done: got %0d expected 122", dc); else passed++;
  endtask

  task automatic test_abort();
    int dc, sm, sh;
    bit seen;
    test_frame("abort", 2, 1, 1'b1, 1'b0, 8, -1, 0, 1'b0, 40, -1, dc, sm, sh);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge pclk); #1;
      if (bus.done_o || bus.busy_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL abort_quiet: got %b expected 0", seen); else passed++;
    test_frame("after_abort", 2, 1, 1'b0, 1'b0, 8, -1, 0, 1'b0, -1, -1, dc, sm, sh);
    checks++; if (dc !== 102) $display("FAIL after_abort_done: got %0d expected 102", dc);
    else passed++;
  endtask

  task automatic test_ignored();
    int dc, sm, sh;
    bit seen;
    bus.frame_len_i = '0;
    bus.start_i = 1'b1;
    @(posedge pclk); #1;
    bus.start_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL len0_start: got %b expected 0", bus.busy_o);
    else passed++;
    bus.frame_len_i = FRAME_W'(8);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(posedge pclk); #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL abort_beats_start: got %b expected 0", bus.busy_o);
    else passed++;
    test_frame("mid_start", 2, 1, 1'b0, 1'b0, 8, -1, 0, 1'b0, -1, 20, dc, sm, sh);
    checks++; if (dc !== 102) $display("FAIL mid_start_done: got %0d expected 102", dc);
    else passed++;
    // Reset in the middle of a frame.
    bus.sppr_i = 3'd2; bus.spr_i = 3'd1; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
    bus.frame_len_i = FRAME_W'(8);
    bus.start_i = 1'b1;
    @(posedge pclk); #1;
    bus.start_i = 1'b0;
    repeat (30) @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    checks++;
    if (observed() !== OW'(0)) $display("FAIL reset_mid: got %b expected %b", observed(), OW'(0));
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge pclk); #1;
      if (bus.done_o || bus.busy_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL reset_no_done: got %b expected 0", seen); else passed++;
  endtask

  task automatic test_max_divisor();
    int dc, sm, sh;
    test_frame("maxdiv", 7, 7, 1'b0, 1'b1, 1, -1, 0, 1'b0, -1, -1, dc, sm, sh);
    checks++; if (dc !== 3072) $display("FAIL maxdiv_done: got %0d expected 3072", dc);
    else passed++;
  endtask

  // Back-to-back random frames; each start lands in the previous frame's done cycle.
  task automatic test_back_to_back_random();
    int dc, sm, sh, n, mid;
    bit cpha;
    for (int f = 0; f < 8; f++) begin
      n    = $urandom_range(1, 31);
      cpha = 1'($urandom_range(0, 1));
      mid  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : -1;
      test_frame("random", $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 cpha, n, -1, 0, 1'b1, -1, mid, dc, sm, sh);
      checks++;
      if (sm !== n) $display("FAIL random_samples f%0d: got %0d expected %0d", f, sm, n);
      else passed++;
      checks++;
      if (sh !== (cpha ? n : n - 1))
        $display("FAIL random_shifts f%0d: got %0d expected %0d", f, sh, cpha ? n : n - 1);
      else passed++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    preset          = 1'b1;
    bus.spi_mode_i  = 2'b00;
    bus.spiswai_i   = 1'b0;
    bus.sppr_i      = '0;
    bus.spr_i       = '0;
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
    bus.frame_len_i = '0;
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    test_reset();
    test_mode0();
    test_mode3_fast();
    test_pause();
    test_abort();
    test_ignored();
    test_max_divisor();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
